// File: rtl/ctrl_pkg.sv
// Shared types for the ALU instruction sequencer: opcodes, branch conditions,
// instruction field positions, FSM states and the ALU function/select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ALU_R = 3'b001,
    OP_ALU_I = 3'b010,
    OP_IN    = 3'b011,
    OP_BR    = 3'b100,
    OP_HALT  = 3'b101,
    OP_ILL6  = 3'b110,
    OP_ILL7  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    CND_ALWAYS = 3'b000,
    CND_Z      = 3'b001,
    CND_NZ     = 3'b010,
    CND_C      = 3'b011,
    CND_N      = 3'b100,
    CND_V      = 3'b101,
    CND_NEVER6 = 3'b110,
    CND_NEVER7 = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Instruction field map (fixed 20-bit encoding)
  localparam int OP_HI  = 19;
  localparam int OP_LO  = 17;
  localparam int FN_HI  = 16;
  localparam int FN_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Bit positions inside {V,N,Z,C}
  localparam int FLG_V = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 0;

  // ALU function codes; RA is zero so a reset IR (NOP) drives an all-zero control word
  localparam logic [2:0] RA   = 3'd0;
  localparam logic [2:0] RB   = 3'd1;
  localparam logic [2:0] RADD = 3'd2;
  localparam logic [2:0] RSUB = 3'd3;
  localparam logic [2:0] RAND = 3'd4;
  localparam logic [2:0] ROR  = 3'd5;
  localparam logic [2:0] RXOR = 3'd6;
  localparam logic [2:0] RNOT = 3'd7;

  // ALU operand sources
  localparam logic [1:0] SEL_REG    = 2'd0;
  localparam logic [1:0] SEL_SW_7_0 = 2'd1;
  localparam logic [1:0] SEL_SW_8   = 2'd2;
  localparam logic [1:0] SEL_IMM    = 2'd3;

  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] flags);
    logic r;
    case (cond_t'(cond))
      CND_ALWAYS: r = 1'b1;
      CND_Z:      r = flags[FLG_Z];
      CND_NZ:     r = ~flags[FLG_Z];
      CND_C:      r = flags[FLG_C];
      CND_N:      r = flags[FLG_N];
      CND_V:      r = flags[FLG_V];
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Purely combinational instruction decode: IR -> ALU control word plus the
// per-instruction side-effect flags the sequencer needs in WB.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [19:0] i_ir,
  output logic [2:0]  o_alu_func,
  output logic [1:0]  o_a_sel,
  output logic [1:0]  o_b_sel,
  output logic [7:0]  o_imm,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_rs,
  output logic [2:0]  o_cond,
  output logic        o_writes,
  output logic        o_sets_flags,
  output logic        o_is_br,
  output logic        o_is_halt,
  output logic        o_is_illegal
);

  logic [2:0] w_op;
  logic [2:0] w_fn;

  assign w_op   = i_ir[OP_HI:OP_LO];
  assign w_fn   = i_ir[FN_HI:FN_LO];
  assign o_rd   = i_ir[RD_HI:RD_LO];
  assign o_rs   = i_ir[RS_HI:RS_LO];
  assign o_imm  = i_ir[IMM_HI:IMM_LO];
  assign o_cond = w_fn;

  always_comb begin
    o_alu_func   = RA;
    o_a_sel      = SEL_REG;
    o_b_sel      = SEL_REG;
    o_writes     = 1'b0;
    o_sets_flags = 1'b0;
    o_is_br      = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (op_t'(w_op))
      OP_ALU_R: begin
        o_alu_func   = w_fn;
        o_writes     = 1'b1;
        o_sets_flags = 1'b1;
      end
      OP_ALU_I: begin
        o_alu_func   = w_fn;
        o_b_sel      = SEL_IMM;
        o_writes     = 1'b1;
        o_sets_flags = 1'b1;
      end
      OP_IN: begin
        // Switch read passes through the ALU as "result = A"
        o_a_sel  = i_ir[IMM_LO] ? SEL_SW_8 : SEL_SW_7_0;
        o_writes = 1'b1;
      end
      OP_BR:   o_is_br = 1'b1;
      OP_HALT: o_is_halt = 1'b1;
      OP_ILL6, OP_ILL7: o_is_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Three-cycle FETCH/EXEC/WB sequencer driving the ALU control interface from a
// synchronous program ROM; owns pc, IR, latched flags and branch resolution.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int n  = 8,
  parameter int PW = 8,
  parameter int IW = 20
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_run,
  input  logic [IW-1:0] i_instr,
  input  logic [3:0]    i_alu_flags,
  output logic [PW-1:0] o_pc,
  output logic [2:0]    o_alu_func,
  output logic [1:0]    o_a_sel,
  output logic [1:0]    o_b_sel,
  output logic [7:0]    o_immidiate,
  output logic [2:0]    o_rd_addr,
  output logic [2:0]    o_rs_addr,
  output logic          o_reg_we,
  output logic [3:0]    o_flags_q,
  output logic          o_halted,
  output logic          o_illegal
);

  if (IW != 20 || PW > 8 || PW < 1 || n < 8) begin : g_bad_cfg
    $error("ctrl_sequencer: field map requires IW=20, 1<=PW<=8, n>=8");
  end

  state_t        r_state;
  logic [PW-1:0] r_pc;
  logic [19:0]   r_ir;
  logic [3:0]    r_flags;
  logic          r_halted;
  logic          r_illegal;

  logic [2:0]    w_cond;
  logic [7:0]    w_imm;
  logic          w_writes;
  logic          w_sets_flags;
  logic          w_is_br;
  logic          w_is_halt;
  logic          w_is_illegal;
  logic          w_taken;
  logic [PW-1:0] w_target;

  ctrl_decode u_decode (
    .i_ir         (r_ir),
    .o_alu_func   (o_alu_func),
    .o_a_sel      (o_a_sel),
    .o_b_sel      (o_b_sel),
    .o_imm        (w_imm),
    .o_rd         (o_rd_addr),
    .o_rs         (o_rs_addr),
    .o_cond       (w_cond),
    .o_writes     (w_writes),
    .o_sets_flags (w_sets_flags),
    .o_is_br      (w_is_br),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  assign w_taken  = w_is_br && cond_met(w_cond, r_flags);
  assign w_target = PW'(w_imm);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_flags   <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: if (i_run) r_state <= ST_EXEC;
        ST_EXEC: begin
          r_ir    <= i_instr[19:0];
          r_state <= ST_WB;
        end
        ST_WB: begin
          if (w_sets_flags) r_flags <= i_alu_flags;
          if (w_is_illegal) r_illegal <= 1'b1;
          if (w_is_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= w_taken ? w_target : r_pc + PW'(1);
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Reset wins over a coincident WB so the register file never sees that write
  assign o_reg_we    = (r_state == ST_WB) && w_writes && !i_reset;
  assign o_immidiate = w_imm;
  assign o_pc        = r_pc;
  assign o_flags_q   = r_flags;
  assign o_halted    = r_halted;
  assign o_illegal   = r_illegal;

endmodule
